// File: rtl/sub_pkg.sv
// Shared types and elaboration helpers for the serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } sub_state_e;

  // Number of digit steps needed to cover a full operand.
  function automatic int unsigned calc_steps(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/digit_subtractor.sv
// Combinational DIGIT-bit ripple subtractor built from full-subtractor cells.
module digit_subtractor #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  // b[i] is the borrow into bit i; b[DIGIT] leaves the digit.
  logic [DIGIT:0] b;

  assign b[0] = bin;

  for (genvar i = 0; i < DIGIT; i++) begin : gen_cell
    assign d[i]   = x[i] ^ y[i] ^ b[i];
    assign b[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & b[i]);
  end

  assign bout = b[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor d = x - y - bin, DIGIT bits per clock, LSB digit first.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             done
);

  localparam int unsigned STEPS = calc_steps(WIDTH, DIGIT);
  localparam int unsigned CntW  = $clog2(STEPS + 1);

  sub_state_e state_q, state_d;

  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [DIGIT-1:0] dig_diff;
  logic             dig_bout;
  logic [WIDTH-1:0] acc_shift;
  logic             accept;
  logic             last_step;

  digit_subtractor #(
    .DIGIT(DIGIT)
  ) u_digit (
    .x   (x_q[DIGIT-1:0]),
    .y   (y_q[DIGIT-1:0]),
    .bin (borrow_q),
    .d   (dig_diff),
    .bout(dig_bout)
  );

  assign accept    = (state_q == StIdle) && start;
  assign last_step = (state_q == StRun) && (cnt_q == CntW'(STEPS - 1));
  // New digit enters from the MSB side; oldest digit drifts toward bit 0.
  assign acc_shift = WIDTH'({dig_diff, acc_q} >> DIGIT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_step) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM-decoded outputs.
  always_comb begin
    ready = (state_q == StIdle);
    done  = (state_q == StDone);
  end

  // Datapath next-state: load on accept, shift one digit per RUN cycle.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    if (accept) begin
      x_d      = x;
      y_d      = y;
      borrow_d = bin;
      cnt_d    = '0;
    end else if (state_q == StRun) begin
      x_d      = x_q >> DIGIT;
      y_d      = y_q >> DIGIT;
      acc_d    = acc_shift;
      borrow_d = dig_bout;
      cnt_d    = cnt_q + CntW'(1);
      if (last_step) begin
        // The top digit is still in the low end of the operand registers,
        // so its MSBs are the original operand sign bits.
        res_d  = acc_shift;
        bout_d = dig_bout;
        ovf_d  = (x_q[DIGIT-1] != y_q[DIGIT-1]) && (dig_diff[DIGIT-1] != x_q[DIGIT-1]);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign d    = res_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: three builds (DIGIT = 4, 1, 16) against a behavioural model.
module tb_serial_subtractor;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         start_a[3];
  logic [W-1:0] x_a[3];
  logic [W-1:0] y_a[3];
  logic         bin_a[3];
  logic         ready_a[3];
  logic [W-1:0] d_a[3];
  logic         bout_a[3];
  logic         ovf_a[3];
  logic         done_a[3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W), .DIGIT(4)) u_dut_d4 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .x(x_a[0]), .y(y_a[0]), .bin(bin_a[0]),
    .ready(ready_a[0]), .d(d_a[0]), .bout(bout_a[0]), .ovf(ovf_a[0]), .done(done_a[0])
  );

  serial_subtractor #(.WIDTH(W), .DIGIT(1)) u_dut_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .x(x_a[1]), .y(y_a[1]), .bin(bin_a[1]),
    .ready(ready_a[1]), .d(d_a[1]), .bout(bout_a[1]), .ovf(ovf_a[1]), .done(done_a[1])
  );

  serial_subtractor #(.WIDTH(W), .DIGIT(16)) u_dut_d16 (
    .clk(clk), .rst_n(rst_n), .start(start_a[2]), .x(x_a[2]), .y(y_a[2]), .bin(bin_a[2]),
    .ready(ready_a[2]), .d(d_a[2]), .bout(bout_a[2]), .ovf(ovf_a[2]), .done(done_a[2])
  );

  // Reference: plain integer subtraction; returns {ovf, bout, d}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    int           diff;
    logic [W-1:0] dd;
    logic         bo;
    logic         ov;
    diff = int'(a) - int'(b) - int'(c);
    dd   = diff[W-1:0];
    bo   = (diff < 0);
    ov   = (a[W-1] != b[W-1]) && (dd[W-1] != a[W-1]);
    return {ov, bo, dd};
  endfunction

  // Wait (bounded) for ready, present one request, return at the negedge after the accept edge.
  task automatic issue(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready_a[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready_a[k] !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready[%0d]: got %b want 1", k, ready_a[k]);
    end
    start_a[k] = 1'b1;
    x_a[k]     = a;
    y_a[k]     = b;
    bin_a[k]   = c;
    @(negedge clk);
    start_a[k] = 1'b0;
  endtask

  // Count negedges until done (bounded at 100).
  task automatic wait_done(input int k, output int lat);
    lat = 0;
    while (!done_a[k] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #2;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ready_a[k] !== 1'b1 || done_a[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl[%0d]: ready=%b done=%b want ready=1 done=0",
                 k, ready_a[k], done_a[k]);
      end
      checks++;
      if (d_a[k] !== 16'h0000 || bout_a[k] !== 1'b0 || ovf_a[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_data[%0d]: d=%h bout=%b ovf=%b want 0000/0/0",
                 k, d_a[k], bout_a[k], ovf_a[k]);
      end
    end
    #10;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] tx[4];
    logic [W-1:0] ty[4];
    logic         tb[4];
    logic [W-1:0] ed[4];
    logic         eb[4];
    logic         eo[4];
    int           lat;
    tx = '{16'h0005, 16'h0003, 16'h8000, 16'h0000};
    ty = '{16'h0003, 16'h0005, 16'h0001, 16'h0000};
    tb = '{1'b0, 1'b0, 1'b0, 1'b1};
    ed = '{16'h0002, 16'hFFFE, 16'h7FFF, 16'hFFFF};
    eb = '{1'b0, 1'b1, 1'b0, 1'b1};
    eo = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      issue(0, tx[i], ty[i], tb[i]);
      wait_done(0, lat);
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL dir_latency[%0d]: got %0d want 4", i, lat);
      end
      checks++;
      if (d_a[0] !== ed[i] || bout_a[0] !== eb[i] || ovf_a[0] !== eo[i]) begin
        errors++;
        $display("FAIL dir_result[%0d]: d=%h bout=%b ovf=%b want %h/%b/%b",
                 i, d_a[0], bout_a[0], ovf_a[0], ed[i], eb[i], eo[i]);
      end
      checks++;
      if (ready_a[0] !== 1'b0) begin
        errors++;
        $display("FAIL dir_ready_in_done[%0d]: got %b want 0", i, ready_a[0]);
      end
      @(negedge clk);
      checks++;
      if (done_a[0] !== 1'b0 || ready_a[0] !== 1'b1 || d_a[0] !== ed[i]) begin
        errors++;
        $display("FAIL dir_after_done[%0d]: done=%b ready=%b d=%h want 0/1/%h",
                 i, done_a[0], ready_a[0], d_a[0], ed[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    issue(0, 16'h0005, 16'h0003, 1'b0);
    start_a[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      x_a[0] = W'($urandom);
      y_a[0] = W'($urandom);
      bin_a[0] = 1'b1;
      if (i < 4) begin
        checks++;
        if (ready_a[0] !== 1'b0) begin
          errors++;
          $display("FAIL busy_ready[%0d]: got %b want 0", i, ready_a[0]);
        end
      end
    end
    checks++;
    if (done_a[0] !== 1'b1 || d_a[0] !== 16'h0002 || bout_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL busy_result: done=%b d=%h bout=%b want 1/0002/0",
               done_a[0], d_a[0], bout_a[0]);
    end
    start_a[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_a[0] !== 1'b1 || d_a[0] !== 16'h0002) begin
      errors++;
      $display("FAIL busy_idle: ready=%b d=%h want 1/0002", ready_a[0], d_a[0]);
    end
  endtask

  task automatic test_reset_midrun();
    bit seen_done;
    issue(0, 16'h1234, 16'h0042, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready_a[0] !== 1'b1 || done_a[0] !== 1'b0 || d_a[0] !== 16'h0000 ||
        bout_a[0] !== 1'b0 || ovf_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: ready=%b done=%b d=%h bout=%b ovf=%b want 1/0/0000/0/0",
               ready_a[0], done_a[0], d_a[0], bout_a[0], ovf_a[0]);
    end
    #2;
    rst_n = 1'b1;
    seen_done = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready: got %b want 1", ready_a[0]);
    end
    for (int i = 0; i < 8; i++) begin
      if (done_a[0] === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen_done !== 1'b0 || d_a[0] !== 16'h0000) begin
      errors++;
      $display("FAIL abort_no_done: done_seen=%b d=%h want 0/0000", seen_done, d_a[0]);
    end
  endtask

  // Back-to-back random operations with start held high; checks results and issue interval.
  task automatic test_back_to_back(input int k, input int steps, input int n);
    logic [W+1:0] q[$];
    logic [W+1:0] e;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    int           cyc;
    int           issued;
    int           finished;
    int           last_acc;
    int           bound;
    cyc      = 0;
    issued   = 0;
    finished = 0;
    last_acc = 0;
    bound    = n * (steps + 2) + 100;
    @(negedge clk);
    while (finished < n && cyc < bound) begin
      if (done_a[k] === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_spurious_done[%0d]: got done with no request pending", k);
        end else begin
          e = q.pop_front();
          if (d_a[k] !== e[W-1:0] || bout_a[k] !== e[W] || ovf_a[k] !== e[W+1]) begin
            errors++;
            $display("FAIL b2b_result[%0d] op %0d: d=%h bout=%b ovf=%b want %h/%b/%b",
                     k, finished, d_a[k], bout_a[k], ovf_a[k], e[W-1:0], e[W], e[W+1]);
          end
        end
        finished++;
      end
      if (ready_a[k] === 1'b1 && issued < n) begin
        if (issued > 0) begin
          checks++;
          if (cyc - last_acc !== steps + 2) begin
            errors++;
            $display("FAIL b2b_interval[%0d]: got %0d want %0d", k, cyc - last_acc, steps + 2);
          end
        end
        a = W'($urandom);
        b = W'($urandom);
        c = 1'($urandom);
        if ($urandom_range(7, 0) == 0) a = 16'h8000;
        if ($urandom_range(7, 0) == 0) b = 16'hFFFF;
        start_a[k] = 1'b1;
        x_a[k]     = a;
        y_a[k]     = b;
        bin_a[k]   = c;
        q.push_back(model(a, b, c));
        last_acc = cyc;
        issued++;
      end else if (issued >= n) begin
        start_a[k] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start_a[k] = 1'b0;
    checks++;
    if (finished !== n) begin
      errors++;
      $display("FAIL b2b_count[%0d]: got %0d results want %0d", k, finished, n);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      start_a[k] = 1'b0;
      x_a[k]     = '0;
      y_a[k]     = '0;
      bin_a[k]   = 1'b0;
    end
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_midrun();
    test_back_to_back(0, 4, 300);
    test_back_to_back(1, 16, 1000);
    test_back_to_back(2, 1, 1000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised multi-cycle subtractor computing `d = x - y - bin` over `WIDTH` bits, processing `DIGIT` bits per clock, LSB digit first. A borrow register chains the digits. It replaces the single-bit combinational full subtractor wherever wide operands must be subtracted with a small area footprint. It uses a start/ready/done handshake so a controller can issue operations back to back.

## Interface
Parameters:
- `WIDTH`, default 16: operand and result width. Must be ≥ 1 and a multiple of `DIGIT`.
- `DIGIT`, default 4: bits processed per cycle, 1 ≤ `DIGIT` ≤ `WIDTH`.
- `STEPS` is derived as `WIDTH/DIGIT` and is not overridable.

Ports:
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: request; accepted only when `ready`=1.
- `x  in  WIDTH`: minuend; sampled on the accepting edge.
- `y  in  WIDTH`: subtrahend; sampled on the accepting edge.
- `bin  in  1`: borrow-in; sampled on the accepting edge.
- `ready  out  1`: high in IDLE only.
- `d  out  WIDTH`: difference; valid from the `done` pulse until the next accept.
- `bout  out  1`: borrow out of the MSB.
- `ovf  out  1`: two's-complement overflow of the signed subtraction.
- `done  out  1`: one-cycle pulse; result valid.

## Operation
States: IDLE, RUN, DONE.
- IDLE: `ready`=1. When `start`=1 at an edge, the block:
  - latches `x` and `y` into operand shift registers,
  - loads `bin` into the borrow register,
  - clears the step counter,
  - enters RUN.
- RUN: on each edge, digit `i` is computed as `x[i] - y[i] - borrow` (DIGIT-bit ripple of full-subtractor cells).
  - The digit result shifts into the result register from the MSB side.
  - The borrow register takes that digit's borrow-out.
  - The counter increments.
  - After the edge that processes digit `STEPS-1`, the block enters DONE.
- DONE: `done`=1 for exactly one cycle. Next edge returns to IDLE.
- `start` is ignored in RUN and DONE. It has no effect on the latched operands.
- `d`, `bout` and `ovf` update together on the final RUN edge. They then hold stable through DONE and IDLE until the next accepted `start`.
- `bout` = borrow after the last digit, i.e. 1 iff `x < y + bin` (unsigned).
- `ovf` = (`x[WIDTH-1]` != `y[WIDTH-1]`) && (`d[WIDTH-1]` != `x[WIDTH-1]`), using the latched operands.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - state=IDLE; `d`=0, `bout`=0, `ovf`=0, `done`=0.
  - Counter and borrow register cleared.
  - `ready`=1 while reset is held.
- Accept at edge 0. Digits are processed on edges 1..`STEPS`. `done`=1 in the cycle after edge `STEPS`. `ready`=1 again after edge `STEPS+1`.
- Latency from accept to `done`: `STEPS` edges. Issue interval: `STEPS+2` cycles.
- `DIGIT`=`WIDTH` gives `STEPS`=1: `done` in the cycle after edge 1.
- Reset mid-RUN or mid-DONE aborts immediately:
  - no `done` pulse,
  - outputs return to reset values,
  - the block is ready in the first cycle after `rst_n` rises.
- Counter width is `$clog2(STEPS+1)`; it never wraps.

## Structure
- Package `sub_pkg` holds the state enum (IDLE/RUN/DONE) and the `STEPS` calculation function.
- Sub-module `digit_subtractor`: combinational, parameter `DIGIT`.
  - Inputs: `x`, `y`, `bin`. Outputs: `d`, `bout`.
  - Built from a generate loop of single-bit full-subtractor equations.
- Top level holds the FSM, step counter, operand shift registers, result register and borrow register.

## Test plan
Default `WIDTH`=16, `DIGIT`=4 unless noted.
- `x`=0x0005, `y`=0x0003, `bin`=0 → `d`=0x0002, `bout`=0, `ovf`=0; `done` in the cycle after edge 4.
- `x`=0x0003, `y`=0x0005, `bin`=0 → `d`=0xFFFE, `bout`=1, `ovf`=0.
- `x`=0x8000, `y`=0x0001, `bin`=0 → `d`=0x7FFF, `bout`=0, `ovf`=1.
- `x`=0x0000, `y`=0x0000, `bin`=1 → `d`=0xFFFF, `bout`=1, `ovf`=0. Verifies borrow ripples through all 4 digits.
- Change `x`/`y` and hold `start` high during RUN → result still matches the first operands and `ready` stays 0. Separately, pulse `rst_n` low after edge 2 → no `done`, `d`=0, `ready`=1.
- `DIGIT`=1 and `DIGIT`=16 builds: 1000 random back-to-back operations. Each result is compared against `(x - y - bin) mod 2^16`, with borrow and overflow checked; the issue interval must equal `STEPS+2`.
